// File: rtl/sd_pkg.sv
// Shared definitions for the time-multiplexed sigma-delta channel sequencer.
//   SD_NCH / SD_W / SD_Q : default channel count, sample width, fractional bits
//   sd_state_t           : sequencer FSM states
//   sd_sample_t          : W-bit signed sample at the default width
//   fullscale(q)         : quantizer full-scale magnitude, 1 << q
package sd_pkg;

    localparam int SD_NCH = 4;
    localparam int SD_W   = 16;
    localparam int SD_Q   = 12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } sd_state_t;

    typedef logic signed [SD_W-1:0] sd_sample_t;

    function automatic int fullscale(input int q);
        return 1 << q;
    endfunction

endpackage

// File: rtl/sd_mod_core.sv
// Combinational 2nd-order sigma-delta update for one channel.
//   in_sample : channel input sample (signed, W bits)
//   z0, z1    : integrator states before the update
//   b         : channel's previous output bit, selects the feedback sign
//   sum0,sum1 : new integrator values (W-bit wrapping arithmetic)
//   mod_bit   : new output bit, sum1 > 0
module sd_mod_core
    import sd_pkg::*;
#(
    parameter int W = SD_W,
    parameter int Q = SD_Q
)(
    input  logic signed [W-1:0] in_sample,
    input  logic signed [W-1:0] z0,
    input  logic signed [W-1:0] z1,
    input  logic                b,
    output logic signed [W-1:0] sum0,
    output logic signed [W-1:0] sum1,
    output logic                mod_bit
);

    localparam logic signed [W-1:0] FS = W'(fullscale(Q));

    logic signed [W-1:0] q;

    always_comb begin
        q       = b ? FS : -FS;
        sum0    = in_sample - q + z0;
        sum1    = sum0 - q + z1;
        // strictly positive: sign clear and not zero
        mod_bit = !sum1[W-1] && (sum1 != '0);
    end

endmodule

// File: rtl/sd_channel_sequencer.sv
// Time-multiplexes one sigma-delta datapath (sd_mod_core) over NCH channels.
// A tick walks channels 0..NCH-1 one per clk, then publishes all bits at once.
//   clk, reset        : clock, asynchronous active-high reset
//   enb               : global enable; low freezes state, FSM and outputs
//   tick              : starts a frame when idle
//   ch_mask           : per-channel enable, sampled when the channel is processed
//   in_data, in_valid : per-channel sample and holding-register load strobe
//   out_bits          : modulator bits, updated after the DONE cycle
//   out_valid         : high during the DONE cycle
//   busy              : FSM not idle
//   overrun, clr_ovr  : sticky "tick while busy" flag and its clear
//
// state   | meaning
// IDLE    | waiting for tick
// RUN     | processing channel ch this cycle
// DONE    | copy staged bits to out_bits, pulse out_valid
module sd_channel_sequencer
    import sd_pkg::*;
#(
    parameter int NCH = SD_NCH,
    parameter int W   = SD_W,
    parameter int Q   = SD_Q
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             enb,
    input  logic             tick,
    input  logic [NCH-1:0]   ch_mask,
    input  logic [NCH*W-1:0] in_data,
    input  logic [NCH-1:0]   in_valid,
    output logic [NCH-1:0]   out_bits,
    output logic             out_valid,
    output logic             busy,
    output logic             overrun,
    input  logic             clr_ovr
);

    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0] LAST_CH = CW'(NCH - 1);

    sd_state_t state, state_nxt;
    logic [CW-1:0] ch;
    logic signed [W-1:0] z0_r [NCH];
    logic signed [W-1:0] z1_r [NCH];
    logic signed [W-1:0] hold_r [NCH];
    logic [NCH-1:0] stage_r;
    logic signed [W-1:0] sum0, sum1;
    logic mod_bit;
    logic step;
    logic publish;
    logic bad_tick;

    sd_mod_core #(.W(W), .Q(Q)) u_core (
        .in_sample (hold_r[ch]),
        .z0        (z0_r[ch]),
        .z1        (z1_r[ch]),
        .b         (stage_r[ch]),
        .sum0      (sum0),
        .sum1      (sum1),
        .mod_bit   (mod_bit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        step      = 1'b0;
        publish   = 1'b0;
        bad_tick  = 1'b0;
        busy      = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (enb && tick) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                step     = enb;
                bad_tick = enb && tick;
                if (enb && (ch == LAST_CH)) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                publish  = enb;
                bad_tick = enb && tick;
                if (enb) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        out_valid = publish;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     ch <= '0;
        else if (step) ch <= (ch == LAST_CH) ? '0 : ch + CW'(1);
    end

    // Processing reads hold_r before this cycle's load lands, so a load in the
    // same cycle as its channel's slot takes effect on the next frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NCH; c++) begin
                z0_r[c]   <= '0;
                z1_r[c]   <= '0;
                hold_r[c] <= '0;
            end
            stage_r  <= '0;
            out_bits <= '0;
        end else begin
            if (enb) begin
                for (int c = 0; c < NCH; c++) begin
                    if (in_valid[c]) hold_r[c] <= in_data[c*W +: W];
                end
            end
            if (step) begin
                if (ch_mask[ch]) begin
                    z0_r[ch]    <= sum0;
                    z1_r[ch]    <= sum1;
                    stage_r[ch] <= mod_bit;
                end else begin
                    z0_r[ch]    <= '0;
                    z1_r[ch]    <= '0;
                    stage_r[ch] <= 1'b0;
                end
            end
            if (publish) out_bits <= stage_r;
        end
    end

    // a new overrun event takes priority over a simultaneous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                overrun <= 1'b0;
        else if (bad_tick)        overrun <= 1'b1;
        else if (enb && clr_ovr)  overrun <= 1'b0;
    end

endmodule

// File: tb/tb_sd_channel_sequencer.sv
// Self-checking bench for sd_channel_sequencer (NCH=4, W=16, Q=12).
// A frame-level reference model applies the modulator equations per tick.
module tb_sd_channel_sequencer;
    import sd_pkg::*;

    localparam int NCH   = 4;
    localparam int W     = 16;
    localparam int Q     = 12;
    localparam int FS_TB = 1 << Q;

    logic             clk;
    logic             reset;
    logic             enb;
    logic             tick;
    logic [NCH-1:0]   ch_mask;
    logic [NCH*W-1:0] in_data;
    logic [NCH-1:0]   in_valid;
    logic [NCH-1:0]   out_bits;
    logic             out_valid;
    logic             busy;
    logic             overrun;
    logic             clr_ovr;

    sd_channel_sequencer #(.NCH(NCH), .W(W), .Q(Q)) dut (
        .clk       (clk),
        .reset     (reset),
        .enb       (enb),
        .tick      (tick),
        .ch_mask   (ch_mask),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_bits  (out_bits),
        .out_valid (out_valid),
        .busy      (busy),
        .overrun   (overrun),
        .clr_ovr   (clr_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // reference model state, one entry per channel
    sd_sample_t m_z0 [NCH];
    sd_sample_t m_z1 [NCH];
    sd_sample_t m_hold [NCH];
    bit         m_b [NCH];
    int         ld_off [NCH];   // cycle offset from tick of a load, -1 = none
    sd_sample_t ld_val [NCH];
    logic [NCH-1:0] obs_bits;

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_z0[c] = 0; m_z1[c] = 0; m_hold[c] = 0; m_b[c] = 0;
        end
    endtask

    task automatic clear_loads();
        for (int c = 0; c < NCH; c++) begin
            ld_off[c] = -1; ld_val[c] = 0;
        end
    endtask

    // Channel c is processed c+1 cycles after the tick; a load strictly before
    // that is used this frame, a later one only from the next frame on.
    task automatic model_frame(input logic [NCH-1:0] mask, output logic [NCH-1:0] exp_bits);
        sd_sample_t x, q, s0, s1;
        for (int c = 0; c < NCH; c++) begin
            x = (ld_off[c] >= 0 && ld_off[c] <= c) ? ld_val[c] : m_hold[c];
            if (!mask[c]) begin
                m_z0[c] = 0; m_z1[c] = 0; m_b[c] = 0;
            end else begin
                q  = m_b[c] ? sd_sample_t'(FS_TB) : sd_sample_t'(-FS_TB);
                s0 = x - q + m_z0[c];
                s1 = s0 - q + m_z1[c];
                m_z0[c] = s0;
                m_z1[c] = s1;
                m_b[c]  = (s1 > 0);
            end
            exp_bits[c] = m_b[c];
            if (ld_off[c] >= 0) m_hold[c] = ld_val[c];
        end
    endtask

    task automatic drive(input int k, input int stall_start, input int stall_len,
                         input int extra_tick, input int clr_at);
        tick    = (k == 0) || (k == extra_tick);
        enb     = !(stall_len > 0 && k >= stall_start && k < stall_start + stall_len);
        clr_ovr = (k == clr_at);
        for (int c = 0; c < NCH; c++) begin
            in_valid[c]       = (ld_off[c] == k);
            in_data[c*W +: W] = ld_val[c];
        end
    endtask

    // Starts and ends just after a rising edge; cycle k counts from the tick cycle.
    task automatic run_frame(input string tag, input logic [NCH-1:0] mask,
                             input int stall_start, input int stall_len,
                             input int extra_tick, input int clr_at);
        logic [NCH-1:0] exp_bits;
        int vk;
        int pulses;
        int k;
        bit done;
        vk = -1; pulses = 0; k = 0; done = 0;
        model_frame(mask, exp_bits);
        ch_mask = mask;
        drive(0, stall_start, stall_len, extra_tick, clr_at);
        while (!done) begin
            @(negedge clk);
            if (out_valid) begin
                pulses++;
                if (vk < 0) vk = k;
            end
            if (k == 1) check_eq({tag, ":busy_run"}, busy, 1);
            if (vk >= 0 && k == vk + 1) begin
                obs_bits = out_bits;
                check_eq({tag, ":bits"}, out_bits, exp_bits);
                check_eq({tag, ":busy_idle"}, busy, 0);
                done = 1;
            end else if (k >= 20) begin
                $display("FAIL %s:timeout: no out_valid within 20 cycles", tag);
                n_checks++;
                n_errors++;
                obs_bits = out_bits;
                done = 1;
            end
            if (!done) begin
                @(posedge clk); #1;
                k++;
                drive(k, stall_start, stall_len, extra_tick, clr_at);
            end
        end
        check_eq({tag, ":latency"}, vk, 5 + stall_len);
        check_eq({tag, ":pulses"}, pulses, 1);
        @(posedge clk); #1;
        tick = 0; in_valid = '0; enb = 1; clr_ovr = 0;
        clear_loads();
    endtask

    task automatic do_reset();
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        model_reset();
    endtask

    logic [NCH-1:0] t1_bits [3];
    logic           seq2 [64];
    int             ones;
    int             stall_s, stall_l;
    logic [NCH-1:0] rmask;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; enb = 1; tick = 0; clr_ovr = 0;
        ch_mask = '1; in_data = '0; in_valid = '0;
        clear_loads();
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        check_eq("rst:out_bits", out_bits, 0);
        check_eq("rst:out_valid", out_valid, 0);
        check_eq("rst:busy", busy, 0);
        check_eq("rst:overrun", overrun, 0);
        @(posedge clk); #1;

        // zero input, three frames
        for (int i = 0; i < 3; i++) begin
            run_frame("t1", 4'hF, 0, 0, -1, -1);
            t1_bits[i] = obs_bits;
        end
        check_eq("t1:f1", t1_bits[0], 4'b1111);
        check_eq("t1:f2", t1_bits[1], 4'b1111);
        check_eq("t1:f3", t1_bits[2], 4'b0000);

        // half-scale on ch2
        do_reset();
        ones = 0;
        for (int i = 0; i < 64; i++) begin
            if (i == 0) begin
                ld_off[2] = 0;
                ld_val[2] = sd_sample_t'(2048);
            end
            run_frame("t2", 4'hF, 0, 0, -1, -1);
            seq2[i] = obs_bits[2];
            if (obs_bits[2]) ones++;
            if (i < 3)
                check_eq("t2:others", {obs_bits[3], obs_bits[1:0]},
                         {t1_bits[i][3], t1_bits[i][1:0]});
        end
        check_eq("t2:density_in_46_50", (ones >= 46 && ones <= 50), 1);

        // overrun
        run_frame("t3a", 4'hF, 0, 0, 2, -1);
        check_eq("t3:ovr_set", overrun, 1);
        run_frame("t3b", 4'hF, 0, 0, 2, 2);
        check_eq("t3:ovr_set_wins", overrun, 1);
        clr_ovr = 1;
        @(posedge clk); #1;
        clr_ovr = 0;
        check_eq("t3:ovr_clr", overrun, 0);
        run_frame("t3c", 4'hF, 0, 0, 5, -1);
        check_eq("t3:ovr_done_tick", overrun, 1);
        clr_ovr = 1;
        @(posedge clk); #1;
        clr_ovr = 0;

        // mask ch2 for one frame, then it must replay the fresh sequence
        run_frame("t4m", 4'b1011, 0, 0, -1, -1);
        check_eq("t4:bit2_masked", obs_bits[2], 0);
        for (int i = 0; i < 8; i++) begin
            run_frame("t4", 4'hF, 0, 0, -1, -1);
            check_eq("t4:seq", obs_bits[2], seq2[i]);
        end

        // enb low for 3 cycles while ch1 is up
        run_frame("t5", 4'hF, 2, 3, -1, -1);

        // random frames: wrapped full-range inputs, masks, in-frame loads, stalls
        for (int i = 0; i < 40; i++) begin
            rmask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            if ($urandom_range(0, 3) == 0) begin
                stall_s = $urandom_range(1, 5);
                stall_l = $urandom_range(1, 3);
            end else begin
                stall_s = 0;
                stall_l = 0;
            end
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 1) == 1) begin
                    ld_off[c] = (stall_l > 0) ? 0 : $urandom_range(0, 6);
                    ld_val[c] = sd_sample_t'($urandom);
                end
            end
            run_frame("rnd", rmask, stall_s, stall_l, -1, -1);
        end

        // reset while ch2 is being processed
        ch_mask = 4'hF;
        tick = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        tick = 0;
        @(negedge clk);
        check_eq("t6:pre_busy", busy, 1);
        check_eq("t6:pre_overrun", overrun, 1);
        @(posedge clk); #1;
        reset = 1;
        @(negedge clk);
        check_eq("t6:out_bits", out_bits, 0);
        check_eq("t6:out_valid", out_valid, 0);
        check_eq("t6:busy", busy, 0);
        check_eq("t6:overrun", overrun, 0);
        @(posedge clk); #1;
        reset = 0;
        model_reset();
        run_frame("t6f", 4'hF, 0, 0, -1, -1);
        check_eq("t6:frame1", obs_bits, 4'b1111);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
